// File: rtl/ariane_pkg.sv
// Minimal slice of the core package: the scoreboard entry seen on the decode/issue boundary.
// Only the fields the issue path touches are modelled here.
package ariane_pkg;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR,
        FPU
    } fu_t;

    typedef struct packed {
        logic [7:0]  cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        exception_t  ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/lsu_sched_pkg.sv
// Shared types and helpers for the LSU issue scheduler.
// Register-conflict check is deliberately conservative: x0 is not exempt.
package lsu_sched_pkg;

    import ariane_pkg::*;

    typedef enum logic [1:0] {
        PASS,
        HOLD,
        DRAIN
    } state_e;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } win_entry_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } regs_t;

    function automatic logic is_mem_op(fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

    // a is the incoming instruction, b a held memory op: RAW, WAW and WAR
    function automatic logic reg_conflict(regs_t a, regs_t b);
        return (a.rs1 == b.rd) || (a.rs2 == b.rd) || (a.rd == b.rd) ||
               (a.rd == b.rs1) || (a.rd == b.rs2);
    endfunction

endpackage

// File: rtl/lsu_sched_hazard.sv
// Purpose: compare one incoming instruction's registers against every valid window entry.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_sched_hazard
    import lsu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  regs_t              in_regs,
    input  regs_t [DEPTH-1:0]  win_regs,
    input  logic  [DEPTH-1:0]  win_vld,
    output logic               hazard,
    output logic  [DEPTH-1:0]  match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = win_vld[i] && reg_conflict(in_regs, win_regs[i]);
        end
    end

    assign hazard = |match;

endmodule

// File: rtl/lsu_issue_scheduler.sv
// Purpose: hold memory ops in an in-order window while the LSU is busy, bypassing independent ops.
// Latency: pass-through/bypass 0 cycles, held ops issue >= 1 cycle after capture.
// Backpressure: stalls upstream on full window, hazard or barrier; LSU_SCHED_PERF_EN adds counters.
module lsu_issue_scheduler
    import ariane_pkg::*;
    import lsu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              debug_req_i,
    input  scoreboard_entry_t issue_entry_i,
    input  logic              issue_entry_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              issue_instr_ack_o,
    output scoreboard_entry_t issue_entry_o,
    output logic              issue_entry_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_instr_ack_i,
    input  logic              lsu_ready_i
`ifdef LSU_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]  bypass_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_IW = $clog2(DEPTH + 1);
    localparam logic [CNT_IW-1:0] DEPTH_C = CNT_IW'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    if (DEPTH < 1 || DEPTH > 4 || CNT_W < 1) begin : g_bad_param
        $error("lsu_issue_scheduler: DEPTH must be 1..4 and CNT_W >= 1");
    end

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    state_e              state_q, state_d;
    win_entry_t          win_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    ptr_t                head_q, tail_q;
    logic [CNT_IW-1:0]   count_q;

    logic                push, pop, bypass;
    logic                in_mem, barrier, hazard;
    logic [DEPTH-1:0]    hz_match;
    regs_t               in_regs;
    regs_t [DEPTH-1:0]   win_regs;
    win_entry_t          head;

    assign in_regs = '{rs1: issue_entry_i.rs1, rs2: issue_entry_i.rs2, rd: issue_entry_i.rd};
    assign head    = win_q[head_q];

    always_comb begin
        win_regs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win_regs[i] = '{rs1: win_q[i].sbe.rs1, rs2: win_q[i].sbe.rs2, rd: win_q[i].sbe.rd};
        end
    end

    lsu_sched_hazard #(.DEPTH(DEPTH)) u_hazard (
        .in_regs  (in_regs),
        .win_regs (win_regs),
        .win_vld  (vld_q),
        .hazard   (hazard),
        .match    (hz_match)
    );

    assign in_mem  = is_mem_op(issue_entry_i.fu);
    assign barrier = is_ctrl_flow_i || (issue_entry_i.fu == CTRL_FLOW) ||
                     issue_entry_i.ex.valid || debug_req_i || hazard;

    always_comb begin
        state_d             = state_q;
        push                = 1'b0;
        pop                 = 1'b0;
        bypass              = 1'b0;
        issue_entry_o       = '0;
        is_ctrl_flow_o      = 1'b0;
        issue_entry_valid_o = 1'b0;
        issue_instr_ack_o   = 1'b0;

        if (!rst_i && !flush_i) begin
            unique case (state_q)
                PASS: begin
                    if (issue_entry_valid_i && in_mem && !lsu_ready_i) begin
                        push              = 1'b1;
                        issue_instr_ack_o = 1'b1;
                        state_d           = HOLD;
                    end else if (issue_entry_valid_i) begin
                        issue_entry_o       = issue_entry_i;
                        is_ctrl_flow_o      = is_ctrl_flow_i;
                        issue_entry_valid_o = 1'b1;
                        issue_instr_ack_o   = issue_instr_ack_i;
                    end
                end
                HOLD, DRAIN: begin
                    if (lsu_ready_i) begin
                        issue_entry_o       = head.sbe;
                        is_ctrl_flow_o      = head.is_ctrl_flow;
                        issue_entry_valid_o = 1'b1;
                        pop                 = issue_instr_ack_i;
                        if (issue_instr_ack_i && count_q == CNT_IW'(1)) begin
                            state_d = PASS;
                        end
                    end else if (state_q == HOLD && issue_entry_valid_i) begin
                        if (!in_mem && !barrier) begin
                            bypass              = 1'b1;
                            issue_entry_o       = issue_entry_i;
                            is_ctrl_flow_o      = is_ctrl_flow_i;
                            issue_entry_valid_o = 1'b1;
                            issue_instr_ack_o   = issue_instr_ack_i;
                        end else if (in_mem && count_q < DEPTH_C) begin
                            push              = 1'b1;
                            issue_instr_ack_o = 1'b1;
                        end else if (!in_mem) begin
                            state_d = DRAIN;
                        end
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= PASS;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= ptr_inc(tail_q);
                count_q       <= count_q + CNT_IW'(1);
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= ptr_inc(head_q);
                count_q       <= count_q - CNT_IW'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed through vld_q/count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            win_q[tail_q] <= '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i};
        end
    end

`ifdef LSU_SCHED_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bypass_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (bypass && issue_instr_ack_i) begin
                bypass_cnt_o <= bypass_cnt_o + CNT_W'(1);
            end
            if (issue_entry_valid_i && !issue_instr_ack_o) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && count_q == '0));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && count_q == DEPTH_C));
    a_match_in_window: assert property (@(posedge clk_i) disable iff (rst_i)
        (hz_match & ~vld_q) == '0);

endmodule

// File: tb/tb_lsu_issue_scheduler.sv
// Directed bench for lsu_issue_scheduler (DEPTH=2): bypass, hazard drain, full window, barriers,
// flush, reset and, with LSU_SCHED_PERF_EN, the performance counters.
module tb_lsu_issue_scheduler;

    import ariane_pkg::*;
    import lsu_sched_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i, flush_i, debug_req_i;
    scoreboard_entry_t issue_entry_i, issue_entry_o;
    logic              issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_o;
    logic              issue_entry_valid_o, is_ctrl_flow_o, issue_instr_ack_i, lsu_ready_i;
`ifdef LSU_SCHED_PERF_EN
    logic [31:0]       bypass_cnt_o, stall_cnt_o;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    lsu_issue_scheduler #(.DEPTH(2), .CNT_W(32)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .debug_req_i         (debug_req_i),
        .issue_entry_i       (issue_entry_i),
        .issue_entry_valid_i (issue_entry_valid_i),
        .is_ctrl_flow_i      (is_ctrl_flow_i),
        .issue_instr_ack_o   (issue_instr_ack_o),
        .issue_entry_o       (issue_entry_o),
        .issue_entry_valid_o (issue_entry_valid_o),
        .is_ctrl_flow_o      (is_ctrl_flow_o),
        .issue_instr_ack_i   (issue_instr_ack_i),
        .lsu_ready_i         (lsu_ready_i)
`ifdef LSU_SCHED_PERF_EN
        ,
        .bypass_cnt_o        (bypass_cnt_o),
        .stall_cnt_o         (stall_cnt_o)
`endif
    );

    function automatic scoreboard_entry_t mk(fu_t fu, logic [4:0] rs1, logic [4:0] rs2,
                                             logic [4:0] rd, logic [31:0] pc);
        scoreboard_entry_t e;
        e     = '0;
        e.fu  = fu;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.rd  = rd;
        e.pc  = pc;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output valid, upstream ack and presented pc (0 whenever nothing is presented)
    task automatic chk_out(input string tag, input logic vld, input logic ack, input logic [31:0] pc);
        #1;
        check({tag, ".vld"}, 64'(issue_entry_valid_o), 64'(vld));
        check({tag, ".ack"}, 64'(issue_instr_ack_o), 64'(ack));
        check({tag, ".pc"},  64'(issue_entry_o.pc), 64'(pc));
    endtask

    task automatic chk_st(input string tag, input int cnt, input state_e st);
        check({tag, ".cnt"},   64'(dut.count_q), 64'(cnt));
        check({tag, ".state"}, 64'(dut.state_q), 64'(st));
    endtask

    task automatic drive(input scoreboard_entry_t e, input logic vld, input logic ctrl,
                         input logic ack, input logic rdy);
        issue_entry_i       = e;
        issue_entry_valid_i = vld;
        is_ctrl_flow_i      = ctrl;
        issue_instr_ack_i   = ack;
        lsu_ready_i         = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        scoreboard_entry_t ld5, add, add_dep, st, lda, ldb, br, nop;
        ld5     = mk(LOAD,      5'd1,  5'd2,  5'd5,  32'h100);
        add     = mk(ALU,       5'd6,  5'd7,  5'd8,  32'h104);
        add_dep = mk(ALU,       5'd5,  5'd9,  5'd10, 32'h108);
        st      = mk(STORE,     5'd11, 5'd12, 5'd13, 32'h200);
        lda     = mk(LOAD,      5'd14, 5'd15, 5'd16, 32'h204);
        ldb     = mk(LOAD,      5'd17, 5'd18, 5'd19, 32'h208);
        br      = mk(CTRL_FLOW, 5'd20, 5'd21, 5'd0,  32'h300);
        nop     = '0;

        rst_i = 1'b1; flush_i = 1'b0; debug_req_i = 1'b0;
        drive(ld5, 1, 0, 1, 1);
        tick();
        chk_out("rst_hold", 0, 0, 0);
        tick();
        rst_i = 1'b0;
        drive(nop, 0, 0, 0, 0);
        chk_out("rst_idle", 0, 0, 0);
        chk_st("rst", 0, PASS);

        // Load held while LSU busy, independent ALU bypasses, then load released
        drive(ld5, 1, 0, 0, 0);
        chk_out("ld_push", 0, 1, 0);
        tick();
        chk_st("ld_push", 1, HOLD);
        drive(add, 1, 0, 1, 0);
        chk_out("bypass", 1, 1, 32'h104);
        tick();
        drive(nop, 0, 0, 0, 1);
        chk_out("head_noack", 1, 0, 32'h100);
        tick();
        chk_st("head_noack", 1, HOLD);
        drive(nop, 0, 0, 1, 1);
        chk_out("head_pop", 1, 0, 32'h100);
        tick();
        chk_st("head_pop", 0, PASS);
        drive(ld5, 1, 0, 1, 1);
        chk_out("pass_mem_ready", 1, 1, 32'h100);
        tick();
        chk_st("pass_mem_ready", 0, PASS);

        // RAW hazard forces drain before the dependent ALU passes
        drive(ld5, 1, 0, 0, 0);
        chk_out("hz_push", 0, 1, 0);
        tick();
        drive(add_dep, 1, 0, 1, 0);
        chk_out("hz_stall", 0, 0, 0);
        tick();
        chk_st("hz_stall", 1, DRAIN);
        drive(add_dep, 1, 0, 1, 1);
        chk_out("hz_drain", 1, 0, 32'h100);
        tick();
        chk_st("hz_drain", 0, PASS);
        chk_out("hz_pass", 1, 1, 32'h108);
        tick();

        // Full window: third memory op stalls, held ops issue in capture order
        drive(st, 1, 0, 0, 0);
        chk_out("full_st", 0, 1, 0);
        tick();
        drive(lda, 1, 0, 0, 0);
        chk_out("full_lda", 0, 1, 0);
        tick();
        chk_st("full_two", 2, HOLD);
        drive(ldb, 1, 0, 1, 0);
        chk_out("full_stall", 0, 0, 0);
        tick();
        chk_st("full_stall", 2, HOLD);
        drive(ldb, 1, 0, 1, 1);
        chk_out("full_pop0", 1, 0, 32'h200);
        tick();
        chk_out("full_pop1", 1, 0, 32'h204);
        tick();
        chk_st("full_empty", 0, PASS);
        chk_out("full_third", 1, 1, 32'h208);
        tick();

        // Branch barrier: drain, no bypass while draining
        drive(st, 1, 0, 0, 0);
        tick();
        drive(br, 1, 1, 1, 0);
        chk_out("br_stall", 0, 0, 0);
        tick();
        chk_st("br_stall", 1, DRAIN);
        drive(add, 1, 0, 1, 0);
        chk_out("drain_nobyp", 0, 0, 0);
        tick();
        chk_st("drain_nobyp", 1, DRAIN);
        drive(br, 1, 1, 1, 1);
        chk_out("br_drain", 1, 0, 32'h200);
        tick();
        chk_st("br_drain", 0, PASS);
        chk_out("br_pass", 1, 1, 32'h300);
        check("br_pass.ctrl", 64'(is_ctrl_flow_o), 64'(1));
        tick();

        // Debug request acts as a barrier
        drive(st, 1, 0, 0, 0);
        tick();
        drive(add, 1, 0, 1, 0);
        debug_req_i = 1'b1;
        chk_out("dbg_stall", 0, 0, 0);
        tick();
        chk_st("dbg_stall", 1, DRAIN);
        debug_req_i = 1'b0;
        drive(add, 1, 0, 1, 1);
        chk_out("dbg_drain", 1, 0, 32'h200);
        tick();
        chk_st("dbg_drain", 0, PASS);

        // Flush with two held ops discards them
        drive(st, 1, 0, 0, 0);
        tick();
        drive(lda, 1, 0, 0, 0);
        tick();
        chk_st("fl_pre", 2, HOLD);
        flush_i = 1'b1;
        drive(add, 1, 0, 1, 1);
        chk_out("fl_cycle", 0, 0, 0);
        tick();
        flush_i = 1'b0;
        chk_st("fl_after", 0, PASS);
        drive(nop, 0, 0, 1, 1);
        chk_out("fl_nothing", 0, 0, 0);
        tick();

        // Reset mid-operation discards the window
        drive(ld5, 1, 0, 0, 0);
        tick();
        chk_st("rs_pre", 1, HOLD);
        rst_i = 1'b1;
        drive(nop, 0, 0, 1, 1);
        chk_out("rs_cycle", 0, 0, 0);
        tick();
        rst_i = 1'b0;
        drive(nop, 0, 0, 0, 0);
        chk_st("rs_after", 0, PASS);
        drive(nop, 0, 0, 1, 1);
        chk_out("rs_nothing", 0, 0, 0);
        tick();

`ifdef LSU_SCHED_PERF_EN
        check("perf_rst.byp", 64'(bypass_cnt_o), 64'(0));
        check("perf_rst.stall", 64'(stall_cnt_o), 64'(0));
        drive(ld5, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(add, 1, 0, 1, 0);
            tick();
        end
        drive(lda, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(ldb, 1, 0, 1, 0);
            tick();
        end
        check("perf.byp", 64'(bypass_cnt_o), 64'(3));
        check("perf.stall", 64'(stall_cnt_o), 64'(4));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
